// File: rtl/gate_vec_checker.sv
// gate_vec_checker: clocked stimulus/check sequencer for the primitive gates
// my_and, my_or and my_not. Walks a fixed 10-entry truth table, waits SETTLE
// cycles per vector, compares the selected gate output and keeps a
// saturating error count with done/pass flags.
//
// Optional build macro: GATE_CHK_STOP_ON_ERR_EN
//   defined   - the first mismatch ends the run (DONE keeps the failing index)
//   undefined - all 10 vectors always run and err_cnt totals the failures
module gate_vec_checker #(
    parameter int SETTLE = 1,   // settle cycles between drive and sample, 1..15
    parameter int ERRW   = 4    // width of err_cnt
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            o_and,
    input  logic            o_or,
    input  logic            o_not,
    output logic            a,
    output logic            b,
    output logic            c,
    output logic            d,
    output logic            e,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            mismatch,
    output logic [3:0]      vec_idx,
    output logic [ERRW-1:0] err_cnt
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRIVE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [3:0] LAST_IDX = 4'd9;

    // Selector for which gate output a vector checks
    localparam logic [1:0] SEL_AND = 2'd0;
    localparam logic [1:0] SEL_OR  = 2'd1;
    localparam logic [1:0] SEL_NOT = 2'd2;

    logic [2:0]      state_q,  state_d;
    logic [4:0]      ins_q,    ins_d;      // {a, b, c, d, e}
    logic [3:0]      settle_q, settle_d;
    logic [3:0]      idx_q,    idx_d;
    logic [ERRW-1:0] err_q,    err_d;
    logic            pass_q,   pass_d;
    logic            mis_q,    mis_d;

    logic [4:0]      vec_ins;
    logic            vec_exp;
    logic [1:0]      vec_sel;
    logic            obs;
    logic            fail;
    logic [ERRW-1:0] err_inc;

    // Truth-table lookup for the current vector index; unused inputs stay 0
    always_comb begin
        vec_ins = 5'b00000;
        vec_exp = 1'b0;
        vec_sel = SEL_NOT;
        if (idx_q < 4'd4) begin
            vec_ins = {idx_q[1], idx_q[0], 3'b000};
            vec_exp = idx_q[1] & idx_q[0];
            vec_sel = SEL_AND;
        end else if (idx_q < 4'd8) begin
            vec_ins = {2'b00, idx_q[1], idx_q[0], 1'b0};
            vec_exp = idx_q[1] | idx_q[0];
            vec_sel = SEL_OR;
        end else begin
            vec_ins = {4'b0000, idx_q[0]};
            vec_exp = ~idx_q[0];
            vec_sel = SEL_NOT;
        end
    end

    // Pick the gate output under test and compare; X/Z must count as a failure
    always_comb begin
        case (vec_sel)
            SEL_AND: obs = o_and;
            SEL_OR:  obs = o_or;
            default: obs = o_not;
        endcase
        fail    = (obs !== vec_exp);
        err_inc = (&err_q) ? err_q : err_q + ERRW'(1);
    end

    // Next-state logic for the sequencer
    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        ins_d    = ins_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        err_d    = err_q;
        pass_d   = pass_q;
        mis_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d   = 4'd0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                ins_d    = vec_ins;
                settle_d = 4'(SETTLE - 1);
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (settle_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_CHECK: begin
                if (fail) begin
                    mis_d = 1'b1;
                    err_d = err_inc;
                end
`ifdef GATE_CHK_STOP_ON_ERR_EN
                if (fail || idx_q == LAST_IDX) begin
`else
                if (idx_q == LAST_IDX) begin
`endif
                    // pass reflects the count including this vector's result
                    pass_d  = (err_d == '0);
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ins_q    <= 5'b00000;
            settle_q <= 4'd0;
            idx_q    <= 4'd0;
            err_q    <= '0;
            pass_q   <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            ins_q    <= ins_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
            mis_q    <= mis_d;
        end
    end

    assign {a, b, c, d, e} = ins_q;
    assign busy     = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign mismatch = mis_q;
    assign vec_idx  = idx_q;
    assign err_cnt  = err_q;

endmodule
